// File: rtl/riscv_dmem_lsq_if.sv
// Request/response bundle between the MEM/WB stages, the access queue and the data bus.
interface riscv_dmem_lsq_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int DST_W = 5
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             flush_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [XLEN-1:0]  req_adr_i;
    logic [XLEN-1:0]  req_d_i;
    logic             req_we_i;
    logic [2:0]       req_size_i;
    logic             req_unsigned_i;
    logic [DST_W-1:0] req_dst_i;
    logic             dmem_req_o;
    logic [XLEN-1:0]  dmem_adr_o;
    logic [XLEN-1:0]  dmem_d_o;
    logic             dmem_we_o;
    logic [2:0]       dmem_size_o;
    logic             dmem_stall_i;
    logic             dmem_ack_i;
    logic             dmem_err_i;
    logic [XLEN-1:0]  dmem_q_i;
    logic             rsp_valid_o;
    logic             rsp_we_o;
    logic [DST_W-1:0] rsp_dst_o;
    logic [XLEN-1:0]  rsp_q_o;
    logic             rsp_err_o;
    logic [XLEN-1:0]  rsp_badaddr_o;
    logic             busy_o;
    logic [CNT_W-1:0] cnt_o;

    modport master (
        output flush_i, req_valid_i, req_adr_i, req_d_i, req_we_i, req_size_i,
               req_unsigned_i, req_dst_i, dmem_stall_i, dmem_ack_i, dmem_err_i, dmem_q_i,
        input  req_ready_o, dmem_req_o, dmem_adr_o, dmem_d_o, dmem_we_o, dmem_size_o,
               rsp_valid_o, rsp_we_o, rsp_dst_o, rsp_q_o, rsp_err_o, rsp_badaddr_o,
               busy_o, cnt_o
    );

    modport slave (
        input  flush_i, req_valid_i, req_adr_i, req_d_i, req_we_i, req_size_i,
               req_unsigned_i, req_dst_i, dmem_stall_i, dmem_ack_i, dmem_err_i, dmem_q_i,
        output req_ready_o, dmem_req_o, dmem_adr_o, dmem_d_o, dmem_we_o, dmem_size_o,
               rsp_valid_o, rsp_we_o, rsp_dst_o, rsp_q_o, rsp_err_o, rsp_badaddr_o,
               busy_o, cnt_o
    );
endinterface

// File: rtl/riscv_dmem_lsq.sv
// In-order multi-outstanding data-memory access queue between MEM and WB.
// Load results are lane-extracted and extended; a flush drops responses already in flight.
module riscv_dmem_lsq #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int DST_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    riscv_dmem_lsq_if.slave  bus
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = $clog2(DEPTH);
    localparam int SHW = (XLEN == 64) ? 3 : 2;

    localparam logic [2:0] BYTE  = 3'b000;
    localparam logic [2:0] HWORD = 3'b001;
    localparam logic [2:0] WORD  = 3'b010;

    typedef struct packed {
        logic [XLEN-1:0]  adr;
        logic [2:0]       size;
        logic             uns;
        logic             we;
        logic [DST_W-1:0] dst;
    } entry_t;

    entry_t           fifo [DEPTH];
    entry_t           head;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt, drop;
    logic             ready, issue, resp, drop_pop, live_pop;
    logic [XLEN-1:0]  lane_q, word_q, ext_q;
    logic             rsp_valid, rsp_we, rsp_err;
    logic [DST_W-1:0] rsp_dst;
    logic [XLEN-1:0]  rsp_q, rsp_badaddr;

    // Slot availability looks only at registered state, so a same-cycle response never frees a slot.
    assign ready    = (({1'b0, cnt} + {1'b0, drop}) < (CW+1)'(DEPTH)) & ~bus.dmem_stall_i & ~rst_i;
    assign issue    = bus.req_valid_i & ready & ~bus.flush_i;
    assign resp     = bus.dmem_ack_i | bus.dmem_err_i;
    assign drop_pop = resp & (drop != '0);
    assign live_pop = resp & (drop == '0) & (cnt != '0);

    assign bus.req_ready_o = ready;
    assign bus.dmem_req_o  = issue;
    assign bus.dmem_adr_o  = rst_i ? '0 : bus.req_adr_i;
    assign bus.dmem_d_o    = rst_i ? '0 : bus.req_d_i;
    assign bus.dmem_we_o   = ~rst_i & bus.req_we_i;
    assign bus.dmem_size_o = rst_i ? '0 : bus.req_size_i;

    assign head = fifo[rd_ptr];

    always_comb begin
        lane_q = bus.dmem_q_i >> {head.adr[SHW-1:0], 3'b000};
        word_q = bus.dmem_q_i >> ((XLEN == 64) ? {head.adr[2], 5'b00000} : 6'd0);
        ext_q  = bus.dmem_q_i;
        case (head.size)
            BYTE:  if (head.uns) ext_q = XLEN'(lane_q[7:0]);
                   else          ext_q = XLEN'($signed(lane_q[7:0]));
            HWORD: if (head.uns) ext_q = XLEN'(lane_q[15:0]);
                   else          ext_q = XLEN'($signed(lane_q[15:0]));
            WORD:  if (head.uns) ext_q = XLEN'(word_q[31:0]);
                   else          ext_q = XLEN'($signed(word_q[31:0]));
            default: ext_q = bus.dmem_q_i;
        endcase
    end

    // Payload storage carries no reset; occupancy is tracked by the counters alone.
    always_ff @(posedge clk_i) begin
        if (issue)
            fifo[wr_ptr] <= '{adr: bus.req_adr_i, size: bus.req_size_i, uns: bus.req_unsigned_i,
                              we: bus.req_we_i, dst: bus.req_dst_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            drop        <= '0;
            rsp_valid   <= 1'b0;
            rsp_we      <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_dst     <= '0;
            rsp_q       <= '0;
            rsp_badaddr <= '0;
        end else begin
            if (issue)
                wr_ptr <= wr_ptr + 1'b1;
            // On flush every live entry becomes a response to be discarded.
            if (bus.flush_i) begin
                cnt    <= '0;
                drop   <= drop - CW'(drop_pop) + cnt - CW'(live_pop);
                rd_ptr <= wr_ptr;
            end else begin
                cnt  <= cnt + CW'(issue) - CW'(live_pop);
                drop <= drop - CW'(drop_pop);
                if (live_pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
            rsp_valid <= live_pop & ~bus.flush_i;
            if (live_pop) begin
                rsp_dst     <= head.dst;
                rsp_err     <= bus.dmem_err_i;
                rsp_we      <= ~head.we & ~bus.dmem_err_i;
                rsp_q       <= (head.we | bus.dmem_err_i) ? '0 : ext_q;
                rsp_badaddr <= bus.dmem_err_i ? head.adr : '0;
            end
        end
    end

    assign bus.rsp_valid_o   = rsp_valid;
    assign bus.rsp_we_o      = rsp_we;
    assign bus.rsp_err_o     = rsp_err;
    assign bus.rsp_dst_o     = rsp_dst;
    assign bus.rsp_q_o       = rsp_q;
    assign bus.rsp_badaddr_o = rsp_badaddr;
    assign bus.busy_o        = (cnt != '0) | (drop != '0);
    assign bus.cnt_o         = cnt;
endmodule

// File: tb/tb_riscv_dmem_lsq.sv
// Directed bench for riscv_dmem_lsq: ordering, backpressure, extraction, flush, errors, reset.
module tb_riscv_dmem_lsq;
    localparam int XLEN = 32, DEPTH = 4, DST_W = 5;
    localparam logic [2:0] BYTE = 3'b000, HWORD = 3'b001, WORD = 3'b010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    riscv_dmem_lsq_if #(.XLEN(XLEN), .DEPTH(DEPTH), .DST_W(DST_W)) bus ();
    riscv_dmem_lsq #(.XLEN(XLEN), .DEPTH(DEPTH), .DST_W(DST_W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic idle();
        bus.flush_i = 0; bus.req_valid_i = 0; bus.req_adr_i = '0; bus.req_d_i = '0;
        bus.req_we_i = 0; bus.req_size_i = WORD; bus.req_unsigned_i = 0; bus.req_dst_i = '0;
        bus.dmem_stall_i = 0; bus.dmem_ack_i = 0; bus.dmem_err_i = 0; bus.dmem_q_i = '0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic reset_dut();
        idle(); rst = 1; tick(); tick(); rst = 0;
    endtask

    task automatic test_reset();
        idle(); rst = 1;
        bus.req_valid_i = 1; bus.req_adr_i = 32'h1234;
        #1;
        checks++; if (bus.dmem_req_o !== 1'b0) begin failures++; $display("FAIL reset_dmem_req got=%b exp=0", bus.dmem_req_o); end
        checks++; if (bus.req_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.req_ready_o); end
        checks++; if (bus.rsp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid_o); end
        checks++; if (bus.cnt_o !== 3'd0 || bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_cnt_busy got=%0d/%b exp=0/0", bus.cnt_o, bus.busy_o); end
        tick(); idle(); rst = 0; #1;
        checks++; if (bus.req_ready_o !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", bus.req_ready_o); end
    endtask

    task automatic test_back_to_back();
        int peak = 0;
        logic exp_v;
        reset_dut();
        for (int c = 0; c < 7; c++) begin
            bus.req_valid_i = (c < 4); bus.req_adr_i = 32'(32'h100 + 4 * c);
            bus.req_size_i = WORD; bus.req_dst_i = DST_W'(c + 1);
            bus.dmem_ack_i = (c >= 2 && c < 6); bus.dmem_q_i = 32'(32'h100 + 4 * (c - 2));
            #1;
            checks++; if (bus.dmem_req_o !== (c < 4)) begin failures++; $display("FAIL b2b_req c=%0d got=%b exp=%b", c, bus.dmem_req_o, (c < 4)); end
            tick();
            if (int'(bus.cnt_o) > peak) peak = int'(bus.cnt_o);
            exp_v = (c >= 2 && c < 6);
            checks++; if (bus.rsp_valid_o !== exp_v) begin failures++; $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, bus.rsp_valid_o, exp_v); end
            if (exp_v) begin
                checks++; if (bus.rsp_q_o !== 32'(32'h100 + 4 * (c - 2))) begin failures++; $display("FAIL b2b_q c=%0d got=%h exp=%h", c, bus.rsp_q_o, 32'(32'h100 + 4 * (c - 2))); end
                checks++; if (bus.rsp_dst_o !== DST_W'(c - 1)) begin failures++; $display("FAIL b2b_dst c=%0d got=%0d exp=%0d", c, bus.rsp_dst_o, c - 1); end
            end
        end
        idle();
        checks++; if (peak != 2) begin failures++; $display("FAIL b2b_peak got=%0d exp=2", peak); end
        checks++; if (bus.cnt_o !== 3'd0 || bus.busy_o !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%0d/%b exp=0/0", bus.cnt_o, bus.busy_o); end
    endtask

    task automatic test_backpressure();
        int nreq = 0;
        reset_dut();
        for (int c = 0; c < 6; c++) begin
            bus.req_valid_i = 1; bus.req_adr_i = 32'(32'h300 + 4 * c);
            #1;
            if (bus.dmem_req_o === 1'b1) nreq++;
            if (c >= 4) begin
                checks++; if (bus.req_ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready_full c=%0d got=%b exp=0", c, bus.req_ready_o); end
            end
            tick();
        end
        checks++; if (nreq != 4) begin failures++; $display("FAIL bp_issued got=%0d exp=4", nreq); end
        checks++; if (bus.cnt_o !== 3'd4) begin failures++; $display("FAIL bp_cnt got=%0d exp=4", bus.cnt_o); end
        bus.dmem_ack_i = 1; #1;
        checks++; if (bus.req_ready_o !== 1'b0 || bus.dmem_req_o !== 1'b0) begin failures++; $display("FAIL bp_same_cycle got=%b/%b exp=0/0", bus.req_ready_o, bus.dmem_req_o); end
        tick();
        bus.dmem_ack_i = 0; bus.req_valid_i = 0; #1;
        checks++; if (bus.req_ready_o !== 1'b1) begin failures++; $display("FAIL bp_ready_next got=%b exp=1", bus.req_ready_o); end
        checks++; if (bus.cnt_o !== 3'd3) begin failures++; $display("FAIL bp_cnt_after got=%0d exp=3", bus.cnt_o); end
        bus.dmem_ack_i = 1; tick(); tick(); tick(); idle();
        checks++; if (bus.cnt_o !== 3'd0) begin failures++; $display("FAIL bp_drained got=%0d exp=0", bus.cnt_o); end
    endtask

    task automatic test_extract();
        logic [31:0] adr_t [7] = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h200, 32'h201, 32'h200};
        logic [2:0]  siz_t [7] = '{BYTE, BYTE, HWORD, HWORD, HWORD, BYTE, WORD};
        logic        uns_t [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] exp_t [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF,
                                   32'h0000_1234, 32'h0000_0012, 32'h80FF_1234};
        reset_dut();
        for (int i = 0; i < 7; i++) begin
            bus.req_valid_i = 1; bus.req_adr_i = adr_t[i]; bus.req_size_i = siz_t[i];
            bus.req_unsigned_i = uns_t[i]; bus.req_dst_i = DST_W'(i + 3);
            #1;
            checks++; if (bus.dmem_size_o !== siz_t[i] || bus.dmem_adr_o !== adr_t[i]) begin failures++; $display("FAIL ext_passthru i=%0d got=%h/%h exp=%h/%h", i, bus.dmem_adr_o, bus.dmem_size_o, adr_t[i], siz_t[i]); end
            tick();
            idle(); bus.dmem_ack_i = 1; bus.dmem_q_i = 32'h80FF_1234;
            tick();
            bus.dmem_ack_i = 0;
            checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_q_o !== exp_t[i]) begin failures++; $display("FAIL ext_q i=%0d got=%b/%h exp=1/%h", i, bus.rsp_valid_o, bus.rsp_q_o, exp_t[i]); end
            checks++; if (bus.rsp_we_o !== 1'b1 || bus.rsp_err_o !== 1'b0 || bus.rsp_dst_o !== DST_W'(i + 3)) begin failures++; $display("FAIL ext_ctl i=%0d got=%b/%b/%0d exp=1/0/%0d", i, bus.rsp_we_o, bus.rsp_err_o, bus.rsp_dst_o, i + 3); end
        end
    endtask

    task automatic test_flush();
        reset_dut();
        for (int c = 0; c < 3; c++) begin
            bus.req_valid_i = 1; bus.req_adr_i = 32'(32'h500 + 4 * c); tick();
        end
        bus.flush_i = 1; bus.req_adr_i = 32'h600; #1;
        checks++; if (bus.dmem_req_o !== 1'b0) begin failures++; $display("FAIL flush_issue got=%b exp=0", bus.dmem_req_o); end
        tick();
        idle();
        checks++; if (bus.cnt_o !== 3'd0 || bus.busy_o !== 1'b1) begin failures++; $display("FAIL flush_state got=%0d/%b exp=0/1", bus.cnt_o, bus.busy_o); end
        for (int k = 0; k < 3; k++) begin
            bus.dmem_ack_i = 1; bus.dmem_q_i = 32'hBAD0_0000; tick();
            checks++; if (bus.rsp_valid_o !== 1'b0) begin failures++; $display("FAIL flush_stale_valid k=%0d got=%b exp=0", k, bus.rsp_valid_o); end
            checks++; if (bus.busy_o !== (k < 2) || bus.cnt_o !== 3'd0) begin failures++; $display("FAIL flush_busy k=%0d got=%b/%0d exp=%b/0", k, bus.busy_o, bus.cnt_o, (k < 2)); end
        end
        idle(); bus.req_valid_i = 1; bus.req_adr_i = 32'h700; bus.req_dst_i = 5'd9; tick();
        idle(); bus.dmem_ack_i = 1; bus.dmem_q_i = 32'h1234_5678; tick();
        idle();
        checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_q_o !== 32'h1234_5678 || bus.rsp_dst_o !== 5'd9) begin failures++; $display("FAIL flush_new_load got=%b/%h/%0d exp=1/12345678/9", bus.rsp_valid_o, bus.rsp_q_o, bus.rsp_dst_o); end
    endtask

    task automatic test_error();
        reset_dut();
        bus.req_valid_i = 1; bus.req_adr_i = 32'h40; bus.req_we_i = 1; bus.req_d_i = 32'hDEAD_BEEF;
        #1;
        checks++; if (bus.dmem_we_o !== 1'b1 || bus.dmem_d_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL err_store_bus got=%b/%h exp=1/deadbeef", bus.dmem_we_o, bus.dmem_d_o); end
        tick();
        idle(); bus.dmem_err_i = 1; bus.dmem_q_i = 32'h5555_5555; tick();
        idle();
        checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b1 || bus.rsp_we_o !== 1'b0) begin failures++; $display("FAIL err_flags got=%b/%b/%b exp=1/1/0", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_we_o); end
        checks++; if (bus.rsp_badaddr_o !== 32'h40) begin failures++; $display("FAIL err_badaddr got=%h exp=00000040", bus.rsp_badaddr_o); end
        bus.req_valid_i = 1; bus.req_adr_i = 32'h44; bus.req_dst_i = 5'd7; tick();
        idle(); bus.dmem_ack_i = 1; bus.dmem_q_i = 32'hCAFE_F00D; tick();
        idle();
        checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b0 || bus.rsp_we_o !== 1'b1 || bus.rsp_q_o !== 32'hCAFE_F00D) begin failures++; $display("FAIL err_next_load got=%b/%b/%b/%h exp=1/0/1/cafef00d", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_we_o, bus.rsp_q_o); end
    endtask

    task automatic test_spurious();
        reset_dut();
        bus.dmem_ack_i = 1; bus.dmem_q_i = 32'hFFFF_FFFF; tick();
        idle();
        checks++; if (bus.rsp_valid_o !== 1'b0 || bus.cnt_o !== 3'd0 || bus.busy_o !== 1'b0) begin failures++; $display("FAIL spur_state got=%b/%0d/%b exp=0/0/0", bus.rsp_valid_o, bus.cnt_o, bus.busy_o); end
        bus.req_valid_i = 1; bus.req_adr_i = 32'h80; #1;
        checks++; if (bus.req_ready_o !== 1'b1) begin failures++; $display("FAIL spur_ready got=%b exp=1", bus.req_ready_o); end
        tick();
        idle(); bus.dmem_ack_i = 1; bus.dmem_q_i = 32'h0000_0080; tick();
        idle();
        checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_q_o !== 32'h80 || bus.cnt_o !== 3'd0) begin failures++; $display("FAIL spur_after got=%b/%h/%0d exp=1/00000080/0", bus.rsp_valid_o, bus.rsp_q_o, bus.cnt_o); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        bus.req_valid_i = 1; bus.req_adr_i = 32'h900; tick();
        bus.req_adr_i = 32'h904; tick();
        bus.req_adr_i = 32'h908; bus.dmem_ack_i = 1; bus.dmem_q_i = 32'h0000_0900; tick();
        bus.dmem_ack_i = 0; bus.req_adr_i = 32'h90C;
        checks++; if (bus.rsp_valid_o !== 1'b1 || bus.cnt_o !== 3'd2) begin failures++; $display("FAIL rstmid_pre got=%b/%0d exp=1/2", bus.rsp_valid_o, bus.cnt_o); end
        rst = 1; #1;
        checks++; if (bus.rsp_valid_o !== 1'b0 || bus.rsp_q_o !== 32'h0 || bus.rsp_dst_o !== 5'd0) begin failures++; $display("FAIL rstmid_rsp got=%b/%h/%0d exp=0/0/0", bus.rsp_valid_o, bus.rsp_q_o, bus.rsp_dst_o); end
        checks++; if (bus.cnt_o !== 3'd0 || bus.busy_o !== 1'b0) begin failures++; $display("FAIL rstmid_cnt got=%0d/%b exp=0/0", bus.cnt_o, bus.busy_o); end
        checks++; if (bus.dmem_req_o !== 1'b0 || bus.req_ready_o !== 1'b0 || bus.dmem_adr_o !== 32'h0) begin failures++; $display("FAIL rstmid_bus got=%b/%b/%h exp=0/0/0", bus.dmem_req_o, bus.req_ready_o, bus.dmem_adr_o); end
        tick(); idle(); rst = 0; tick();
    endtask

    initial begin
        idle();
        tick();
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_extract();
        test_flush();
        test_error();
        test_spurious();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
